// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: mode record, the 640x480@60 defaults the
// generator elaborates with, an 800x600@60 alternate preset, and small helpers.
package vga_timing_pkg;

   // Timing of one axis: region lengths plus the asserted sync level
   typedef struct packed {
      logic [15:0] active;
      logic [15:0] fp;
      logic [15:0] sync;
      logic [15:0] bp;
      logic        pol;
   } vga_axis_t;

   // A complete display mode: horizontal in pixels, vertical in lines
   typedef struct packed {
      vga_axis_t h;
      vga_axis_t v;
   } vga_mode_t;

   // Selector for the built-in presets
   typedef enum logic [0:0] {
      MODE_SEL_640X480_60 = 1'b0,
      MODE_SEL_800X600_60 = 1'b1
   } vga_mode_sel_t;

   // 640x480@60 at a 25 MHz pixel clock, both syncs active-low
   localparam vga_mode_t MODE_640X480_60 = '{
      h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48, pol: 1'b0},
      v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33, pol: 1'b0}
   };

   // 800x600@60 at a 40 MHz pixel clock, both syncs active-high
   localparam vga_mode_t MODE_800X600_60 = '{
      h: '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88, pol: 1'b1},
      v: '{active: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23, pol: 1'b1}
   };

   // Elaboration defaults of the generator (100 MHz system clock, /4)
   localparam int   DEF_CLK_DIV  = 4;
   localparam int   DEF_CW       = 11;
   localparam int   DEF_H_ACTIVE = int'(MODE_640X480_60.h.active);
   localparam int   DEF_H_FP     = int'(MODE_640X480_60.h.fp);
   localparam int   DEF_H_SYNC   = int'(MODE_640X480_60.h.sync);
   localparam int   DEF_H_BP     = int'(MODE_640X480_60.h.bp);
   localparam int   DEF_V_ACTIVE = int'(MODE_640X480_60.v.active);
   localparam int   DEF_V_FP     = int'(MODE_640X480_60.v.fp);
   localparam int   DEF_V_SYNC   = int'(MODE_640X480_60.v.sync);
   localparam int   DEF_V_BP     = int'(MODE_640X480_60.v.bp);
   localparam logic DEF_HS_POL   = MODE_640X480_60.h.pol;
   localparam logic DEF_VS_POL   = MODE_640X480_60.v.pol;

   // Total period of one axis (active + porches + sync)
   function automatic int axis_total(input vga_axis_t a);
      return int'(a.active) + int'(a.fp) + int'(a.sync) + int'(a.bp);
   endfunction

   // Preset lookup by selector
   function automatic vga_mode_t mode_lookup(input vga_mode_sel_t sel);
      return (sel == MODE_SEL_800X600_60) ? MODE_800X600_60 : MODE_640X480_60;
   endfunction

   // Drive level of a sync output given whether the pulse is on
   function automatic logic sync_level(input logic pulse_on, input logic pol);
      return pulse_on ? pol : ~pol;
   endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate divider: counts enabled system clocks 0..CLK_DIV-1 and flags the
// last count so the timing counters advance once per pixel.
module pix_tick_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic pix_tick
);

   localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] r_div;
   logic          w_div_last;

   // With CLK_DIV=1 the counter sits at 0 == DIV_LAST, so every enabled clock ticks
   assign w_div_last = (r_div == DIV_LAST);
   assign pix_tick   = en & w_div_last;

   // Divider advances only while enabled and otherwise keeps its phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
      end else if (en) begin
         r_div <= w_div_last ? '0 : r_div + DW'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blanking and start-of-line/frame decode, all aligned to the x/y update.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   CLK_DIV  = DEF_CLK_DIV,
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic HS_POL   = DEF_HS_POL,
   parameter logic VS_POL   = DEF_VS_POL,
   parameter int   CW       = DEF_CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic          pix_tick,
   output logic          hsync,
   output logic          vsync,
   output logic          active,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Reject configurations the counters cannot represent
   if (CLK_DIV < 1) begin : g_bad_clk_div
      $fatal(1, "vga_timing_gen: CLK_DIV must be at least 1");
   end
   if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
      $fatal(1, "vga_timing_gen: sync pulse widths must be non-zero");
   end
   if ((longint'(H_TOTAL) - 1) > ((longint'(1) << CW) - 1)) begin : g_bad_h_total
      $fatal(1, "vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
   end
   if ((longint'(V_TOTAL) - 1) > ((longint'(1) << CW) - 1)) begin : g_bad_v_total
      $fatal(1, "vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
   end

   localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] X_ACTIVE = CW'(H_ACTIVE);
   localparam logic [CW-1:0] Y_ACTIVE = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic          w_tick;
   logic          w_x_wrap;
   logic          w_y_wrap;
   logic [CW-1:0] w_x_nxt;
   logic [CW-1:0] w_y_nxt;
   logic          w_hs_on_nxt;
   logic          w_vs_on_nxt;
   logic          w_active_nxt;

   logic [CW-1:0] r_x;
   logic [CW-1:0] r_y;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_active;
   logic          r_pix_tick;
   logic          r_line_start;
   logic          r_frame_start;
   logic [7:0]    r_frame_cnt;

   pix_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_tick_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .pix_tick (w_tick)
   );

   // Next raster position; reset parks at the last pixel so the first tick lands on (0,0)
   assign w_x_wrap = (r_x == X_LAST);
   assign w_y_wrap = (r_y == Y_LAST);
   assign w_x_nxt  = w_x_wrap ? '0 : r_x + CW'(1);
   assign w_y_nxt  = w_x_wrap ? (w_y_wrap ? '0 : r_y + CW'(1)) : r_y;

   // Decode is taken from the next position so registered outputs match the new x/y
   assign w_hs_on_nxt  = (w_x_nxt >= HS_FIRST) && (w_x_nxt <= HS_LAST);
   assign w_vs_on_nxt  = (w_y_nxt >= VS_FIRST) && (w_y_nxt <= VS_LAST);
   assign w_active_nxt = (w_x_nxt < X_ACTIVE) && (w_y_nxt < Y_ACTIVE);

   // One-clock strobes: only asserted on the edge that moves the raster
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix_tick    <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_pix_tick    <= w_tick;
         r_line_start  <= w_tick & w_x_wrap;
         r_frame_start <= w_tick & w_x_wrap & w_y_wrap;
      end
   end

   // Position, level outputs and frame counter update together on each pixel tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x         <= X_LAST;
         r_y         <= Y_LAST;
         r_hsync     <= ~HS_POL;
         r_vsync     <= ~VS_POL;
         r_active    <= 1'b0;
         r_frame_cnt <= 8'hFF;
      end else if (w_tick) begin
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_hsync  <= sync_level(w_hs_on_nxt, HS_POL);
         r_vsync  <= sync_level(w_vs_on_nxt, VS_POL);
         r_active <= w_active_nxt;
         if (w_x_wrap && w_y_wrap) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign pix_tick    = r_pix_tick;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign active      = r_active;
   assign x           = r_x;
   assign y           = r_y;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two small modes (divided and
// undivided pixel clock, opposite sync polarities) driven with random enable.
module tb_vga_timing_gen;

   // Mode A: divided pixel clock, active-low hsync, active-high vsync
   localparam int   A_DIV = 3;
   localparam int   A_HA = 6, A_HF = 1, A_HS = 2, A_HB = 1;
   localparam int   A_VA = 3, A_VF = 1, A_VS = 1, A_VB = 1;
   localparam logic A_HP = 1'b0, A_VP = 1'b1;
   // Mode B: one clock per pixel, active-high hsync, active-low vsync
   localparam int   B_DIV = 1;
   localparam int   B_HA = 8, B_HF = 1, B_HS = 2, B_HB = 1;
   localparam int   B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
   localparam logic B_HP = 1'b1, B_VP = 1'b0;

   typedef struct packed {
      logic        tick;
      logic [10:0] x;
      logic [10:0] y;
      logic        hs;
      logic        vs;
      logic        act;
      logic        ls;
      logic        fs;
      logic [7:0]  fc;
   } obs_t;

   typedef struct {
      int unsigned cyc;
      obs_t        o;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic en    = 1'b0;

   logic        a_tick, a_hs, a_vs, a_act, a_ls, a_fs;
   logic [10:0] a_x, a_y;
   logic [7:0]  a_fc;
   logic        b_tick, b_hs, b_vs, b_act, b_ls, b_fs;
   logic [10:0] b_x, b_y;
   logic [7:0]  b_fc;
   obs_t        obs_a, obs_b;

   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   obs_t        last_a, last_b;
   obs_t        hold_a, hold_b;
   exp_t        pop_a, pop_b;
   int          enc, ka, kb;

   vga_timing_gen #(
      .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
      .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
      .HS_POL(A_HP), .VS_POL(A_VP), .CW(11)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(a_tick), .hsync(a_hs),
      .vsync(a_vs), .active(a_act), .x(a_x), .y(a_y), .line_start(a_ls),
      .frame_start(a_fs), .frame_cnt(a_fc)
   );

   vga_timing_gen #(
      .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
      .HS_POL(B_HP), .VS_POL(B_VP), .CW(11)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(b_tick), .hsync(b_hs),
      .vsync(b_vs), .active(b_act), .x(b_x), .y(b_y), .line_start(b_ls),
      .frame_start(b_fs), .frame_cnt(b_fc)
   );

   assign obs_a = {a_tick, a_x, a_y, a_hs, a_vs, a_act, a_ls, a_fs, a_fc};
   assign obs_b = {b_tick, b_x, b_y, b_hs, b_vs, b_act, b_ls, b_fs, b_fc};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected outputs right after the k-th pixel tick since reset (k >= 1)
   function automatic obs_t model(input int k, input int ha, input int hf, input int hs,
                                  input int hb, input int va, input int vf, input int vs,
                                  input int vb, input logic hp, input logic vp);
      obs_t o;
      int ht, vt, p, xx, yy;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      p  = (k - 1) % (ht * vt);
      xx = p % ht;
      yy = p / ht;
      o.tick = 1'b1;
      o.x    = 11'(xx);
      o.y    = 11'(yy);
      o.hs   = (xx >= ha + hf && xx < ha + hf + hs) ? hp : ~hp;
      o.vs   = (yy >= va + vf && yy < va + vf + vs) ? vp : ~vp;
      o.act  = (xx < ha) && (yy < va);
      o.ls   = (xx == 0);
      o.fs   = (p == 0);
      o.fc   = 8'(((k - 1) / (ht * vt)) % 256);
      return o;
   endfunction

   function automatic obs_t rst_state(input int ht, input int vt, input logic hp, input logic vp);
      obs_t o;
      o.tick = 1'b0;
      o.x    = 11'(ht - 1);
      o.y    = 11'(vt - 1);
      o.hs   = ~hp;
      o.vs   = ~vp;
      o.act  = 1'b0;
      o.ls   = 1'b0;
      o.fs   = 1'b0;
      o.fc   = 8'hFF;
      return o;
   endfunction

   task automatic cmp(input string nm, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got tick=%0b x=%0d y=%0d hs=%0b vs=%0b act=%0b ls=%0b fs=%0b fc=%0d expected tick=%0b x=%0d y=%0d hs=%0b vs=%0b act=%0b ls=%0b fs=%0b fc=%0d",
                  nm, cyc, act.tick, act.x, act.y, act.hs, act.vs, act.act, act.ls, act.fs, act.fc,
                  exp.tick, exp.x, exp.y, exp.hs, exp.vs, exp.act, exp.ls, exp.fs, exp.fc);
      end
   endtask

   // Monitor A: pop on the expected tick cycle, otherwise outputs must hold with strobes low
   always @(negedge clk) begin
      if (rst_n) begin
         if (qa.size() != 0 && qa[0].cyc == cyc) begin
            pop_a  = qa.pop_front();
            last_a = pop_a.o;
            cmp("A_tick", obs_a, pop_a.o);
         end else begin
            hold_a      = last_a;
            hold_a.tick = 1'b0;
            hold_a.ls   = 1'b0;
            hold_a.fs   = 1'b0;
            cmp("A_hold", obs_a, hold_a);
         end
      end
   end

   // Monitor B: same scheme for the undivided mode
   always @(negedge clk) begin
      if (rst_n) begin
         if (qb.size() != 0 && qb[0].cyc == cyc) begin
            pop_b  = qb.pop_front();
            last_b = pop_b.o;
            cmp("B_tick", obs_b, pop_b.o);
         end else begin
            hold_b      = last_b;
            hold_b.tick = 1'b0;
            hold_b.ls   = 1'b0;
            hold_b.fs   = 1'b0;
            cmp("B_hold", obs_b, hold_b);
         end
      end
   end

   // Asynchronous reset mid-cycle, checked before the next clock edge
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      cmp("A_rst_async", obs_a, rst_state(A_HA + A_HF + A_HS + A_HB, A_VA + A_VF + A_VS + A_VB, A_HP, A_VP));
      cmp("B_rst_async", obs_b, rst_state(B_HA + B_HF + B_HS + B_HB, B_VA + B_VF + B_VS + B_VB, B_HP, B_VP));
      qa.delete();
      qb.delete();
      enc = 0;
      ka  = 0;
      kb  = 0;
      last_a = rst_state(A_HA + A_HF + A_HS + A_HB, A_VA + A_VF + A_VS + A_VB, A_HP, A_VP);
      last_b = rst_state(B_HA + B_HF + B_HS + B_HB, B_VA + B_VF + B_VS + B_VB, B_HP, B_VP);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Issue n cycles of enable (pct% chance high) and queue the ticks they must produce
   task automatic run(input int n, input int pct);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         en = ($urandom_range(99) < pct);
         if (en) begin
            enc++;
            if (enc % A_DIV == 0) begin
               ka++;
               e.cyc = cyc + 1;
               e.o   = model(ka, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_HP, A_VP);
               qa.push_back(e);
            end
            if (enc % B_DIV == 0) begin
               kb++;
               e.cyc = cyc + 1;
               e.o   = model(kb, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_HP, B_VP);
               qb.push_back(e);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1;
      do_reset();
      run(60, 100);
      run(400, 60);
      run(50, 0);
      run(100, 100);
      run(int'($urandom_range(150, 40)), 100);
      do_reset();
      run(47000, 100);
      run(1500, 50);
      do_reset();
      run(30, 100);
      @(negedge clk);
      #1;
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain pending_a=%0d pending_b=%0d required 0", qa.size(), qb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel (100 MHz -> 25 MHz pixel rate).
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines.
REQ-004 Parameters HS_POL and VS_POL, default 0: asserted sync level (0 = active-low).
REQ-005 Parameter CW, default 11: width of the x/y counters.
REQ-006 clk  input  1: single system clock; all logic on its rising edge.
REQ-007 rst_n  input  1: asynchronous, active-low reset.
REQ-008 en  input  1: timing run enable.
REQ-009 pix_tick  output  1: one-clk pixel-enable strobe.
REQ-010 hsync, vsync  output  1 each: sync pulses at the configured polarity.
REQ-011 active  output  1: current pixel is in the visible area.
REQ-012 x, y  output  CW each: current horizontal and vertical position.
REQ-013 line_start, frame_start  output  1 each: one-clk pulses.
REQ-014 frame_cnt  output  8: frame counter.

Function
REQ-015 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP shall be derived constants.
REQ-016 Elaboration shall fail if CLK_DIV<1, if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1, or if any sync width is 0.
REQ-017 The divider shall count 0..CLK_DIV-1 while en=1; pix_tick=1 in the cycle it equals CLK_DIV-1; CLK_DIV=1 gives pix_tick=1 every enabled cycle.
REQ-018 On pix_tick, x shall advance by 1; at H_TOTAL-1, x wraps to 0 and y advances; at V_TOTAL-1 with x wrap, y wraps to 0.
REQ-019 All outputs shall be registered and updated on the same edge as x/y, so they describe the new position with zero extra latency.
REQ-020 hsync shall equal HS_POL exactly when H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1, otherwise ~HS_POL.
REQ-021 vsync shall equal VS_POL exactly when V_ACTIVE+V_FP <= y <= V_ACTIVE+V_FP+V_SYNC-1, otherwise ~VS_POL.
REQ-022 active shall be 1 exactly when x<H_ACTIVE and y<V_ACTIVE.
REQ-023 line_start shall be 1 for one clk when x becomes 0.
REQ-024 frame_start shall be 1 for one clk when (x,y) becomes (0,0); line_start is also 1 in that cycle.
REQ-025 frame_cnt shall increment modulo 256 in the frame_start cycle.
REQ-026 With en=0: divider, x, y, sync, active and frame_cnt hold; pix_tick, line_start and frame_start are 0; on return to en=1, counting resumes from the held divider value.

Reset
REQ-027 While rst_n=0, without waiting for a clock edge: divider=0, x=H_TOTAL-1, y=V_TOTAL-1, hsync=~HS_POL, vsync=~VS_POL, active=0, pix_tick/line_start/frame_start=0, frame_cnt=8'hFF.
REQ-028 The first pix_tick after reset release shall wrap to (0,0), assert frame_start, and set frame_cnt=0.
REQ-029 Reset asserted mid-frame shall abort the frame immediately; no partial pulse shall persist.

Structure
REQ-030 Package vga_timing_pkg shall hold the default 640x480@60 constants, a mode record typedef (active, fp, sync, bp, polarity per axis), and an alternate 800x600 preset.
REQ-031 The divider shall be the sub-module pix_tick_gen (params CLK_DIV; ports clk, rst_n, en, pix_tick); counters and decode stay in vga_timing_gen.

Verification
REQ-032 Defaults, rst_n released: 4th enabled clk -> pix_tick=1, x=0, y=0, active=1, line_start=1, frame_start=1, frame_cnt=0.
REQ-033 Defaults, line y=0: hsync=0 for exactly 96 ticks (384 clk), x=656..751; active=0 from x=640; next line_start 3200 clk after the previous one.
REQ-034 Defaults, full frame: frame_start period 1,680,000 clk; vsync=0 only for y=490..491; frame_cnt 0->1; after 256 frames it wraps 255->0.
REQ-035 en=0 for 50 clk with x=100: x stays 100, no pix_tick or pulses; after en=1, the next tick gives x=101 at the held divider phase.
REQ-036 rst_n pulled low asynchronously at x=300, y=200: outputs take the REQ-027 values before the next clk edge; resume per REQ-028.
REQ-037 CLK_DIV=1, H 8/1/2/1, V 4/1/1/1, HS_POL=1: pix_tick constant 1; hsync=1 for x=9..10; line period 12 clk; frame period 84 clk.
